// File: rtl/clock_ratio_monitor.sv
// clock_ratio_monitor
//
// Watches a divided or gated clock (mon_clk_in) that is sampled as plain data
// in the clk domain. It recovers the divide ratio from the high and low phase
// lengths, reports whether the monitored clock is running, flags malformed
// periods, and compares the locked ratio against an expected divider select.
//
// Optional feature: define CLK_MON_ERR_CNT_EN to build the 8-bit saturating
// glitch counter behind err_count. When it is undefined, err_count is tied to 0.
//
// Parameters
//   TIMEOUT           clk cycles without any mon_clk_in edge before the input
//                     is declared stopped (9..255)
// Ports
//   clk               sampling clock
//   rst               synchronous, active-high reset
//   mon_clk_in        monitored clock, asynchronous to clk in principle
//   expected_div_sel  01=/2, 10=/4, 11=/8, 00=full rate (never checked)
//   check_en          enables ratio_mismatch
//   glitch_clr        one-cycle clear of glitch_err (and err_count)
//   clk_active        monitor is out of IDLE, so an edge was seen recently
//   div_valid         measured_div is locked
//   measured_div      recovered divider encoding
//   period_len        last complete period in clk cycles, saturating at 15
//   ratio_mismatch    registered mismatch between measured and expected ratio
//   glitch_err        sticky malformed-period flag
//   err_count         glitch counter (0 unless CLK_MON_ERR_CNT_EN)
//
// There is no valid/ready handshake here: every input is sampled on each
// rising clk edge, and every output is a level.
module clock_ratio_monitor #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mon_clk_in,
  input  logic [1:0] expected_div_sel,
  input  logic       check_en,
  input  logic       glitch_clr,
  output logic       clk_active,
  output logic       div_valid,
  output logic [1:0] measured_div,
  output logic [3:0] period_len,
  output logic       ratio_mismatch,
  output logic       glitch_err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  // The idle counter holds "cycles since the last edge minus one", so the
  // TIMEOUT-th quiet cycle is the one where it reads TIMEOUT-1.
  localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

  logic       s1_q, s2_q, s3_q;
  logic [3:0] hi_cnt_q, hi_cnt_d;
  logic [3:0] lo_cnt_q, lo_cnt_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  state_t     state_q, state_d;
  logic [1:0] cand_q, cand_d;
  logic [1:0] measured_div_q, measured_div_d;
  logic [3:0] period_len_q, period_len_d;
  logic       ratio_mismatch_q, ratio_mismatch_d;
  logic       glitch_err_q, glitch_err_d;

  logic       rise, fall, any_edge, timeout, glitch;
  logic [4:0] period_sum;
  logic       period_ok;
  logic [1:0] period_enc;

  assign rise     = s2_q & ~s3_q;
  assign fall     = ~s2_q & s3_q;
  assign any_edge = rise | fall;
  // An edge in the same cycle always wins over a timeout.
  assign timeout  = (state_q != ST_IDLE) && !any_edge && (idle_cnt_q >= IDLE_LIMIT);

  // At a rising edge, hi_cnt_q holds the previous high phase and lo_cnt_q
  // holds the low phase that just ended.
  assign period_sum = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};

  always_comb begin
    period_ok  = 1'b0;
    period_enc = 2'b00;
    if (hi_cnt_q == lo_cnt_q) begin
      if (period_sum == 5'd2) begin
        period_ok  = 1'b1;
        period_enc = 2'b01;
      end else if (period_sum == 5'd4) begin
        period_ok  = 1'b1;
        period_enc = 2'b10;
      end else if (period_sum == 5'd8) begin
        period_ok  = 1'b1;
        period_enc = 2'b11;
      end
    end
  end

  // Phase and idle counters
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    lo_cnt_d = lo_cnt_q;
    if (rise) begin
      hi_cnt_d = 4'd1;
    end else if (s2_q && hi_cnt_q != 4'd15) begin
      hi_cnt_d = hi_cnt_q + 4'd1;
    end
    if (fall) begin
      lo_cnt_d = 4'd1;
    end else if (!s2_q && lo_cnt_q != 4'd15) begin
      lo_cnt_d = lo_cnt_q + 4'd1;
    end
    // The first rise out of IDLE restarts measurement, so a partial first
    // period is never judged.
    if (state_q == ST_IDLE && rise) begin
      lo_cnt_d = 4'd0;
    end

    idle_cnt_d = idle_cnt_q;
    if (any_edge) begin
      idle_cnt_d = 8'd0;
    end else if (idle_cnt_q != 8'hff) begin
      idle_cnt_d = idle_cnt_q + 8'd1;
    end
  end

  // Lock FSM: next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    cand_d         = cand_q;
    measured_div_d = measured_div_q;
    period_len_d   = period_len_q;
    glitch         = 1'b0;

    if (rise && state_q != ST_IDLE) begin
      period_len_d = (period_sum > 5'd15) ? 4'd15 : period_sum[3:0];
    end

    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (rise) begin
          if (period_ok) begin
            cand_d  = period_enc;
            state_d = ST_CONFIRM;
          end else begin
            glitch = 1'b1;
          end
        end
      end
      ST_CONFIRM: begin
        if (rise) begin
          if (!period_ok) begin
            glitch  = 1'b1;
            state_d = ST_ACQUIRE;
          end else if (period_enc == cand_q) begin
            measured_div_d = cand_q;
            state_d        = ST_LOCKED;
          end else begin
            cand_d = period_enc;
          end
        end
      end
      ST_LOCKED: begin
        if (rise) begin
          if (!period_ok) begin
            glitch  = 1'b1;
            state_d = ST_ACQUIRE;
          end else if (period_enc != cand_q) begin
            cand_d  = period_enc;
            state_d = ST_CONFIRM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      state_d = ST_IDLE;
    end
  end

  // div_valid is exactly "in LOCKED": every exit from LOCKED drops it.
  assign div_valid  = (state_q == ST_LOCKED);
  assign clk_active = (state_q != ST_IDLE);

  assign ratio_mismatch_d = check_en && div_valid && (expected_div_sel != 2'b00) &&
                            (measured_div_q != expected_div_sel);

  // A glitch in the same cycle as a clear keeps the flag set.
  assign glitch_err_d = glitch ? 1'b1 : (glitch_clr ? 1'b0 : glitch_err_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q             <= 1'b0;
      s2_q             <= 1'b0;
      s3_q             <= 1'b0;
      hi_cnt_q         <= 4'd0;
      lo_cnt_q         <= 4'd0;
      idle_cnt_q       <= 8'd0;
      state_q          <= ST_IDLE;
      cand_q           <= 2'b00;
      measured_div_q   <= 2'b00;
      period_len_q     <= 4'd0;
      ratio_mismatch_q <= 1'b0;
      glitch_err_q     <= 1'b0;
    end else begin
      s1_q             <= mon_clk_in;
      s2_q             <= s1_q;
      s3_q             <= s2_q;
      hi_cnt_q         <= hi_cnt_d;
      lo_cnt_q         <= lo_cnt_d;
      idle_cnt_q       <= idle_cnt_d;
      state_q          <= state_d;
      cand_q           <= cand_d;
      measured_div_q   <= measured_div_d;
      period_len_q     <= period_len_d;
      ratio_mismatch_q <= ratio_mismatch_d;
      glitch_err_q     <= glitch_err_d;
    end
  end

  assign measured_div   = measured_div_q;
  assign period_len     = period_len_q;
  assign ratio_mismatch = ratio_mismatch_q;
  assign glitch_err     = glitch_err_q;

`ifdef CLK_MON_ERR_CNT_EN
  logic [7:0] err_count_q, err_count_d;

  // A glitch coinciding with a clear restarts the count at 1.
  always_comb begin
    err_count_d = err_count_q;
    if (glitch && glitch_clr) begin
      err_count_d = 8'd1;
    end else if (glitch) begin
      if (err_count_q != 8'hff) err_count_d = err_count_q + 8'd1;
    end else if (glitch_clr) begin
      err_count_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Directed testbench for clock_ratio_monitor (TIMEOUT = 16).
// Inputs change on the falling clk edge and outputs are sampled there too,
// half a cycle away from the sampling edge of the DUT.
module tb_clock_ratio_monitor;

  logic       clk;
  logic       rst;
  logic       mon_clk_in;
  logic [1:0] expected_div_sel;
  logic       check_en;
  logic       glitch_clr;
  logic       clk_active;
  logic       div_valid;
  logic [1:0] measured_div;
  logic [3:0] period_len;
  logic       ratio_mismatch;
  logic       glitch_err;
  logic [7:0] err_count;

`ifdef CLK_MON_ERR_CNT_EN
  localparam int ERR_CNT_ON = 1;
`else
  localparam int ERR_CNT_ON = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  clock_ratio_monitor #(.TIMEOUT(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .mon_clk_in       (mon_clk_in),
    .expected_div_sel (expected_div_sel),
    .check_en         (check_en),
    .glitch_clr       (glitch_clr),
    .clk_active       (clk_active),
    .div_valid        (div_valid),
    .measured_div     (measured_div),
    .period_len       (period_len),
    .ratio_mismatch   (ratio_mismatch),
    .glitch_err       (glitch_err),
    .err_count        (err_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of the monitored clock, then wait to the next falling edge.
  task automatic step(input logic v);
    mon_clk_in = v;
    @(negedge clk);
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) step(1'b1);
      for (int i = 0; i < lo; i++) step(1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_clk_active"},     32'(clk_active),     32'd0);
    check_eq({tag, "_div_valid"},      32'(div_valid),      32'd0);
    check_eq({tag, "_measured_div"},   32'(measured_div),   32'd0);
    check_eq({tag, "_period_len"},     32'(period_len),     32'd0);
    check_eq({tag, "_ratio_mismatch"}, 32'(ratio_mismatch), 32'd0);
    check_eq({tag, "_glitch_err"},     32'(glitch_err),     32'd0);
    check_eq({tag, "_err_count"},      32'(err_count),      32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    mon_clk_in       = 1'b0;
    expected_div_sel = 2'b00;
    check_en         = 1'b0;
    glitch_clr       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0);
    check_eq("idle_low_clk_active", 32'(clk_active), 32'd0);

    // Lock at /4: first rise is detected 2 cycles after it is driven, and
    // div_valid follows 2 periods plus 1 cycle later (cycle 11 overall).
    for (int c = 0; c < 16; c++) begin
      step((c % 4) < 2);
      if (c + 1 == 10) check_eq("lock4_not_yet", 32'(div_valid), 32'd0);
      if (c + 1 == 11) check_eq("lock4_valid",   32'(div_valid), 32'd1);
      if (c + 1 == 3)  check_eq("lock4_active",  32'(clk_active), 32'd1);
    end
    check_eq("lock4_measured",   32'(measured_div), 32'd2);
    check_eq("lock4_period_len", 32'(period_len),   32'd4);
    check_eq("lock4_glitch",     32'(glitch_err),   32'd0);

    // Mismatch against /8 while locked at /4
    expected_div_sel = 2'b11;
    check_en         = 1'b1;
    wave(2, 2, 1);
    check_eq("mm_set", 32'(ratio_mismatch), 32'd1);
    expected_div_sel = 2'b00;
    step(1'b1);
    check_eq("mm_full_rate_suppressed", 32'(ratio_mismatch), 32'd0);
    step(1'b1); step(1'b0); step(1'b0);
    expected_div_sel = 2'b11;
    step(1'b1);
    check_eq("mm_reassert", 32'(ratio_mismatch), 32'd1);
    check_en = 1'b0;
    step(1'b1);
    check_eq("mm_check_en_off", 32'(ratio_mismatch), 32'd0);
    step(1'b0); step(1'b0);
    expected_div_sel = 2'b10;
    check_en         = 1'b1;
    wave(2, 2, 1);
    check_eq("mm_match", 32'(ratio_mismatch), 32'd0);
    check_en         = 1'b0;
    expected_div_sel = 2'b00;

    // Glitch: one 1-high/3-low period inside a /4 stream
    wave(1, 3, 1);
    wave(2, 2, 1);
    check_eq("glitch_flag",      32'(glitch_err), 32'd1);
    check_eq("glitch_div_valid", 32'(div_valid),  32'd0);
    check_eq("glitch_err_count", 32'(err_count),  32'(ERR_CNT_ON));
    glitch_clr = 1'b1;
    step(1'b1);
    glitch_clr = 1'b0;
    check_eq("glitch_clr_flag",  32'(glitch_err), 32'd0);
    check_eq("glitch_clr_count", 32'(err_count),  32'd0);
    step(1'b1); step(1'b0); step(1'b0);
    wave(2, 2, 2);
    check_eq("relock4_valid",    32'(div_valid),    32'd1);
    check_eq("relock4_measured", 32'(measured_div), 32'd2);

    // Glitch detected in the same cycle as glitch_clr: set wins
    wave(1, 3, 1);
    step(1'b1);
    step(1'b1);
    glitch_clr = 1'b1;
    step(1'b0);
    glitch_clr = 1'b0;
    check_eq("setwins_flag",  32'(glitch_err), 32'd1);
    check_eq("setwins_count", 32'(err_count),  32'(ERR_CNT_ON));
    step(1'b0);
    glitch_clr = 1'b1;
    step(1'b1);
    glitch_clr = 1'b0;
    step(1'b1); step(1'b0); step(1'b0);
    check_eq("setwins_cleared", 32'(glitch_err), 32'd0);

    // Ratio change /2 -> /8 at a high-low boundary
    wave(1, 1, 6);
    check_eq("lock2_valid",      32'(div_valid),    32'd1);
    check_eq("lock2_measured",   32'(measured_div), 32'd1);
    check_eq("lock2_period_len", 32'(period_len),   32'd2);
    wave(4, 4, 2);
    check_eq("chg_valid_drop", 32'(div_valid),  32'd0);
    check_eq("chg_glitch_0",   32'(glitch_err), 32'd0);
    wave(4, 4, 1);
    check_eq("lock8_valid",      32'(div_valid),    32'd1);
    check_eq("lock8_measured",   32'(measured_div), 32'd3);
    check_eq("lock8_period_len", 32'(period_len),   32'd8);
    check_eq("lock8_glitch_0",   32'(glitch_err),   32'd0);

    // Stop: lock at /2, then hold low. The last fall reaches s2 one edge
    // after the final step returns; clk_active drops 17 edges after that.
    wave(1, 1, 4);
    check_eq("stop_pre_valid",    32'(div_valid),    32'd1);
    check_eq("stop_pre_measured", 32'(measured_div), 32'd1);
    for (int j = 1; j <= 18; j++) begin
      step(1'b0);
      if (j == 17) check_eq("stop_still_active", 32'(clk_active), 32'd1);
      if (j == 18) begin
        check_eq("stop_active_0",   32'(clk_active),   32'd0);
        check_eq("stop_valid_0",    32'(div_valid),    32'd0);
        check_eq("stop_hold_meas",  32'(measured_div), 32'd1);
      end
    end

    // Reset while LOCKED with a live mismatch, then relock
    wave(1, 1, 4);
    check_eq("rst_pre_valid", 32'(div_valid), 32'd1);
    check_en         = 1'b1;
    expected_div_sel = 2'b11;
    step(1'b1);
    step(1'b0);
    check_eq("rst_pre_mismatch", 32'(ratio_mismatch), 32'd1);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    check_all_zero("rst_mid");
    step(1'b0);
    wave(1, 1, 5);
    check_eq("rst_relock_valid",    32'(div_valid),      32'd1);
    check_eq("rst_relock_measured", 32'(measured_div),   32'd1);
    check_eq("rst_relock_mismatch", 32'(ratio_mismatch), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
